// File: rtl/extra_cycle_shifter_n_if.sv
// Control/status bundle for the extra-cycle shifter: T1/ready/clear in, stage lines and status out.
interface extra_cycle_shifter_n_if #(
  parameter int STAGES = 4,
  parameter int NUM_W  = 4
);
  logic              T1;
  logic              n_ready;
  logic              TRES2;
  logic [STAGES-1:0] n_T;
  logic [NUM_W-1:0]  t_num;
  logic              multi;
  logic              tail;

  modport master (
    output T1, n_ready, TRES2,
    input  n_T, t_num, multi, tail
  );

  modport slave (
    input  T1, n_ready, TRES2,
    output n_T, t_num, multi, tail
  );
endinterface

// File: rtl/extra_cycle_shifter_n.sv
// Parametrised T2..T(STAGES+1) extra-cycle shift chain with T-number, overlap flag and tail pulse.
module extra_cycle_shifter_n #(
  parameter int STAGES = 4,
  parameter int NUM_W  = 4
) (
  input logic                    CLK,
  input logic                    n_RES,
  extra_cycle_shifter_n_if.slave bus
);

  logic [STAGES-1:0] r_s;
  logic              r_tail;
  logic [NUM_W-1:0]  w_t_num;
  logic              w_multi;

  // Clear beats stall beats shift; the chain carries arbitrary patterns, not just one-hot.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      r_s    <= '0;
      r_tail <= 1'b0;
    end else if (bus.TRES2) begin
      r_s    <= '0;
      r_tail <= 1'b0;
    end else if (bus.n_ready) begin
      r_tail <= 1'b0;
    end else begin
      r_s    <= {r_s[STAGES-2:0], bus.T1};
      r_tail <= r_s[STAGES-1];
    end
  end

  // Highest set stage wins; later iterations override earlier ones.
  always_comb begin
    w_t_num = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (r_s[k]) w_t_num = NUM_W'(k + 2);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi = |(r_s & (r_s - STAGES'(1)));

  assign bus.n_T   = ~r_s;
  assign bus.t_num = w_t_num;
  assign bus.multi = w_multi;
  assign bus.tail  = r_tail;

endmodule

// File: tb/tb_extra_cycle_shifter_n.sv
// Directed table-driven bench for extra_cycle_shifter_n (STAGES=4) plus a STAGES=6 instance.
module tb_extra_cycle_shifter_n;

  logic CLK;
  logic n_RES;
  int   checks;
  int   errors;

  extra_cycle_shifter_n_if #(.STAGES(4), .NUM_W(4)) bus4 ();
  extra_cycle_shifter_n_if #(.STAGES(6), .NUM_W(4)) bus6 ();

  extra_cycle_shifter_n #(.STAGES(4), .NUM_W(4)) dut4 (
    .CLK   (CLK),
    .n_RES (n_RES),
    .bus   (bus4)
  );

  extra_cycle_shifter_n #(.STAGES(6), .NUM_W(4)) dut6 (
    .CLK   (CLK),
    .n_RES (n_RES),
    .bus   (bus6)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       t1;
    logic       nrdy;
    logic       tres2;
    logic [3:0] nt;
    logic [3:0] tnum;
    logic       multi;
    logic       tail;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic t1, input logic nrdy, input logic tres2,
                     input logic [3:0] nt, input logic [3:0] tnum,
                     input logic multi, input logic tail);
    vec_t v;
    v.t1 = t1; v.nrdy = nrdy; v.tres2 = tres2;
    v.nt = nt; v.tnum = tnum; v.multi = multi; v.tail = tail;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] nt, input logic [3:0] tnum,
                      input logic multi, input logic tail);
    chk({tag, " n_T"},   32'(bus4.n_T),   32'(nt));
    chk({tag, " t_num"}, 32'(bus4.t_num), 32'(tnum));
    chk({tag, " multi"}, 32'(bus4.multi), 32'(multi));
    chk({tag, " tail"},  32'(bus4.tail),  32'(tail));
  endtask

  task automatic step4(input logic t1, input logic nrdy, input logic tres2);
    bus4.T1 = t1; bus4.n_ready = nrdy; bus4.TRES2 = tres2;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_RES  = 1'b0;
    bus4.T1 = 0; bus4.n_ready = 0; bus4.TRES2 = 0;
    bus6.T1 = 0; bus6.n_ready = 0; bus6.TRES2 = 0;

    // single token
    add(1,0,0, 4'b1110, 2, 0, 0);
    add(0,0,0, 4'b1101, 3, 0, 0);
    add(0,0,0, 4'b1011, 4, 0, 0);
    add(0,0,0, 4'b0111, 5, 0, 0);
    add(0,0,0, 4'b1111, 0, 0, 1);
    add(0,0,0, 4'b1111, 0, 0, 0);
    // stall at T3 with a lost T1
    add(1,0,0, 4'b1110, 2, 0, 0);
    add(0,0,0, 4'b1101, 3, 0, 0);
    add(1,1,0, 4'b1101, 3, 0, 0);
    add(0,1,0, 4'b1101, 3, 0, 0);
    add(0,1,0, 4'b1101, 3, 0, 0);
    add(0,1,0, 4'b1101, 3, 0, 0);
    add(0,0,0, 4'b1011, 4, 0, 0);
    add(0,0,0, 4'b0111, 5, 0, 0);
    add(0,0,0, 4'b1111, 0, 0, 1);
    add(0,0,0, 4'b1111, 0, 0, 0);
    // clear at T3 with simultaneous T1
    add(1,0,0, 4'b1110, 2, 0, 0);
    add(0,0,0, 4'b1101, 3, 0, 0);
    add(1,0,1, 4'b1111, 0, 0, 0);
    add(0,0,1, 4'b1111, 0, 0, 0);
    add(0,0,1, 4'b1111, 0, 0, 0);
    add(0,0,1, 4'b1111, 0, 0, 0);
    add(0,0,0, 4'b1111, 0, 0, 0);
    add(0,0,0, 4'b1111, 0, 0, 0);
    // overlap
    add(1,0,0, 4'b1110, 2, 0, 0);
    add(1,0,0, 4'b1100, 3, 1, 0);
    add(0,0,0, 4'b1001, 4, 1, 0);
    add(0,0,0, 4'b0011, 5, 1, 0);
    add(0,0,0, 4'b0111, 5, 0, 1);
    add(0,0,0, 4'b1111, 0, 0, 1);
    add(0,0,0, 4'b1111, 0, 0, 0);
    // stall on last stage
    add(1,0,0, 4'b1110, 2, 0, 0);
    add(0,0,0, 4'b1101, 3, 0, 0);
    add(0,0,0, 4'b1011, 4, 0, 0);
    add(0,0,0, 4'b0111, 5, 0, 0);
    add(0,1,0, 4'b0111, 5, 0, 0);
    add(0,1,0, 4'b0111, 5, 0, 0);
    add(0,0,0, 4'b1111, 0, 0, 1);
    add(0,0,0, 4'b1111, 0, 0, 0);
    // clear while token on last stage suppresses tail
    add(1,0,0, 4'b1110, 2, 0, 0);
    add(0,0,0, 4'b1101, 3, 0, 0);
    add(0,0,0, 4'b1011, 4, 0, 0);
    add(0,0,0, 4'b0111, 5, 0, 0);
    add(0,0,1, 4'b1111, 0, 0, 0);
    add(0,0,0, 4'b1111, 0, 0, 0);

    repeat (2) @(posedge CLK);
    #1;
    chk4("reset", 4'b1111, 0, 0, 0);
    chk("reset6 n_T", 32'(bus6.n_T), 32'h3f);
    n_RES = 1'b1;

    foreach (vq[i]) begin
      step4(vq[i].t1, vq[i].nrdy, vq[i].tres2);
      chk4($sformatf("vec%0d", i), vq[i].nt, vq[i].tnum, vq[i].multi, vq[i].tail);
    end

    // async reset with token at T4, no clock edge involved
    step4(1,0,0); step4(0,0,0); step4(0,0,0);
    chk4("pre_rst", 4'b1011, 4, 0, 0);
    #2 n_RES = 1'b0;
    #1 chk4("async_rst", 4'b1111, 0, 0, 0);
    #1 n_RES = 1'b1;
    // async reset kills a pending tail
    step4(1,0,0); step4(0,0,0); step4(0,0,0); step4(0,0,0); step4(0,0,0);
    chk4("tail_pre", 4'b1111, 0, 0, 1);
    #1 n_RES = 1'b0;
    #1 chk4("async_tail", 4'b1111, 0, 0, 0);
    #1 n_RES = 1'b1;
    // first edge after release is a normal cycle
    step4(1,0,0);
    chk4("post_rst", 4'b1110, 2, 0, 0);
    step4(0,0,0);
    chk4("post_rst2", 4'b1101, 3, 0, 0);

    // STAGES=6 single token
    bus6.T1 = 1'b1;
    @(posedge CLK); #1;
    bus6.T1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [5:0] ent;
      logic [3:0] etn;
      ent = (i < 6) ? ~(6'b1 << i) : 6'h3f;
      etn = (i < 6) ? 4'(i + 2) : 4'd0;
      chk($sformatf("s6 n_T %0d", i),   32'(bus6.n_T),   32'(ent));
      chk($sformatf("s6 t_num %0d", i), 32'(bus6.t_num), 32'(etn));
      chk($sformatf("s6 tail %0d", i),  32'(bus6.tail),  32'(i == 6));
      chk($sformatf("s6 multi %0d", i), 32'(bus6.multi), 32'(0));
      @(posedge CLK); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/extra_cycle_shifter_n.md
Name: extra_cycle_shifter_n

Overview:
- Parametrised successor to the 6502 T2–T5 extra-cycle counter.
- A one-hot token loaded from T1 advances through STAGES stages, one per ready cycle. The chain stalls while not ready and clears on TRES2.
- Adds what the fixed 4-stage block lacks: the active T-number in binary, an overlap flag and a registered "token left the chain" pulse.
- Sits in the dispatch/timing area and feeds the decoder's T2..T(STAGES+1) lines on a single-clock core.

Parameters:
- STAGES, 4, number of extra-cycle stages (min 2, max 14). The stages drive T2..T(STAGES+1).
- NUM_W, 4, width of t_num. Must be at least clog2(STAGES+2).

Ports:
- CLK  input  1  single core clock; all state updates on the rising edge.
- n_RES  input  1  asynchronous active-low reset.
- T1  input  1  token input; shifted into stage 0 on a ready cycle.
- n_ready  input  1  active-low ready; when 1 the chain holds.
- TRES2  input  1  synchronous clear of the whole chain; highest synchronous priority.
- n_T  output  STAGES  active-low stage lines. Bit k low means stage T(k+2) is active.
- t_num  output  NUM_W  T-number of the most advanced active stage (2..STAGES+1); 0 when idle.
- multi  output  1  more than one stage is active.
- tail  output  1  registered one-cycle pulse when the token leaves the last stage.

Behaviour:
- State:
  - s[STAGES-1:0], active-high. Stage k corresponds to T(k+2).
  - One tail flop.
- Reset: n_RES low, asynchronously → s=0 and tail=0. Outputs then read n_T = all ones, t_num = 0, multi = 0, tail = 0.
- Per rising CLK edge (n_RES high), in priority order:
  1. TRES2=1: s ← 0, tail ← 0. T1 and n_ready are ignored.
  2. n_ready=1: s holds and tail ← 0. T1 is ignored; a T1 pulse during a stall is lost.
  3. Otherwise: s ← {s[STAGES-2:0], T1} and tail ← s[STAGES-1].
- Latency:
  - T1 high at edge e with ready → n_T[0] low after edge e.
  - With continuous ready, n_T[k] is low after edge e+k.
  - tail pulses for one cycle after edge e+STAGES.
- Combinational outputs from s only:
  - n_T = ~s.
  - t_num = (highest set index k) + 2, or 0 if s = 0.
  - multi = popcount(s) > 1.
- Boundary cases:
  - Back-to-back T1 produces overlapping tokens. The chain must carry any bit pattern, not only one-hot; multi flags it.
  - Stall on the last stage: the token stays and tail does not fire until the shift cycle.
  - TRES2 in the same cycle as T1: the chain clears and the T1 token is discarded.
  - Reset mid-operation: immediate clear regardless of CLK.
  - On release of n_RES, the first edge behaves as a normal cycle.
- No combinational path from any input to any output. All outputs derive from flops.

Test Plan (STAGES=4 unless noted):
- Idle then single token:
  - Stimulus: T1=1 for one ready cycle.
  - Required: n_T steps through 1110, 1101, 1011, 0111, 1111 on consecutive cycles.
  - Required: t_num reads 2, 3, 4, 5, 0.
  - Required: tail=1 only in the cycle after n_T=0111; multi stays 0.
- Stall:
  - Stimulus: token at T3, then n_ready=1 for 4 cycles, then n_ready=0.
  - Required: n_T=1101 held for 4 cycles, then resumes 1011, 0111.
  - Required: a T1 pulse issued during the stall never appears.
- Clear:
  - Stimulus: token at T3, TRES2=1 for 4 cycles with T1=1 in the first of them.
  - Required: n_T=1111 and t_num=0 from the next edge; no tail pulse.
  - Required: after TRES2=0 with T1=0, the chain stays idle.
- Overlap:
  - Stimulus: T1=1 on two consecutive ready cycles.
  - Required: n_T goes 1110, then 1100 (multi=1, t_num=3), then 1001, 0011.
  - Required: tail is high for 2 cycles after 0011.
- Async reset:
  - Stimulus: token at T4, pulse n_RES low between clock edges.
  - Required: n_T=1111 and tail=0 immediately, not waiting for CLK.
- STAGES=6, NUM_W=4:
  - Stimulus: single token.
  - Required: t_num walks 2..7 then 0; tail follows 6 edges after the T1 edge.
